// File: rtl/bhand_pack_pkg.sv
// rtl/bhand_pack_pkg.sv - shared types and helpers for the bhand_pack stream upsizer
package bhand_pack_pkg;

    // The FILL/HOLD state doubles as the output valid flag.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

    localparam int RESET_ASYNC_HIGH = 0;
    localparam int RESET_SYNC_LOW   = 1;

    // Derives the lane counter width from RATIO when an instantiator wants it.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bhand_pack.sv
// rtl/bhand_pack.sv - packs RATIO narrow valid/ready beats into one wide word with lane keep
module bhand_pack
    import bhand_pack_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int RATIO       = 4,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       idata,
    input  logic                        idata_vld,
    input  logic                        idata_last,
    output logic                        idata_rdy,
    output logic [DATA_WIDTH*RATIO-1:0] odata,
    output logic [RATIO-1:0]            odata_keep,
    output logic                        odata_last,
    output logic                        odata_vld,
    input  logic                        odata_rdy
);

    localparam int WORD_WIDTH = DATA_WIDTH * RATIO;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(RATIO - 1);

    pack_state_t            state_q, state_d;
    logic [WORD_WIDTH-1:0]  acc_q, acc_d;
    logic [RATIO-1:0]       keep_q, keep_d;
    logic                   last_q, last_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic in_xfer;
    logic out_xfer;

    // odata_rdy -> idata_rdy is a deliberate combinational path for full throughput.
    assign idata_rdy = !rst && ((state_q == FILL) || odata_rdy);
    assign in_xfer   = idata_vld && idata_rdy;
    assign out_xfer  = (state_q == HOLD) && odata_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            acc_q   <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        keep_d  = keep_q;
        last_d  = last_q;
        count_d = count_q;

        // Draining the held word starts a fresh, empty word first.
        if (out_xfer) begin
            state_d = FILL;
            acc_d   = '0;
            keep_d  = '0;
            last_d  = 1'b0;
            count_d = '0;
        end

        if (in_xfer) begin
            for (int k = 0; k < RATIO; k++) begin
                if (count_d == COUNT_WIDTH'(k)) begin
                    acc_d[k*DATA_WIDTH +: DATA_WIDTH] = idata;
                    keep_d[k]                         = 1'b1;
                end
            end
            if (idata_last || (count_d == COUNT_LAST)) begin
                state_d = HOLD;
                last_d  = idata_last;
                count_d = '0;
            end else begin
                count_d = count_d + COUNT_ONE;
            end
        end
    end

    assign odata_vld  = (state_q == HOLD);
    assign odata      = acc_q;
    assign odata_keep = keep_q;
    assign odata_last = last_q;

endmodule

// File: tb/tb_bhand_pack.sv
// tb/tb_bhand_pack.sv - directed self-checking bench for bhand_pack (DATA_WIDTH=8, RATIO=4)
module tb_bhand_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  idata;
    logic        idata_vld;
    logic        idata_last;
    logic        idata_rdy;
    logic [31:0] odata;
    logic [3:0]  odata_keep;
    logic        odata_last;
    logic        odata_vld;
    logic        odata_rdy;

    int checks = 0;
    int passed = 0;

    bhand_pack #(.DATA_WIDTH(8), .RATIO(4), .COUNT_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .idata      (idata),
        .idata_vld  (idata_vld),
        .idata_last (idata_last),
        .idata_rdy  (idata_rdy),
        .odata      (odata),
        .odata_keep (odata_keep),
        .odata_last (odata_last),
        .odata_vld  (odata_vld),
        .odata_rdy  (odata_rdy)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] d, input logic l);
        idata      = d;
        idata_last = l;
        idata_vld  = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        idata_vld  = 1'b0;
        idata_last = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idata = '0; idata_vld = 1'b0; idata_last = 1'b0; odata_rdy = 1'b1;
        @(posedge clk); #1;
        checks++; if (odata_vld !== 1'b0) $display("FAIL reset_vld got %b want 0", odata_vld); else passed++;
        checks++; if (odata !== 32'h0) $display("FAIL reset_data got %h want 00000000", odata); else passed++;
        checks++; if (odata_keep !== 4'b0000) $display("FAIL reset_keep got %b want 0000", odata_keep); else passed++;
        checks++; if (odata_last !== 1'b0) $display("FAIL reset_last got %b want 0", odata_last); else passed++;
        checks++; if (idata_rdy !== 1'b0) $display("FAIL reset_rdy got %b want 0", idata_rdy); else passed++;
        rst = 1'b0;
        #1;
        checks++; if (idata_rdy !== 1'b1) $display("FAIL post_reset_rdy got %b want 1", idata_rdy); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_streaming();
        logic [7:0] beats [4];
        logic       rdy_ok;
        logic       early_vld;
        beats = '{8'h11, 8'h22, 8'h33, 8'h44};
        rdy_ok = 1'b1; early_vld = 1'b0;
        odata_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idata = beats[i]; idata_vld = 1'b1; idata_last = 1'b0;
            #1;
            if (idata_rdy !== 1'b1) rdy_ok = 1'b0;
            if (i > 0 && odata_vld !== 1'b0) early_vld = 1'b1;
            send(beats[i], 1'b0);
        end
        checks++; if (!rdy_ok) $display("FAIL stream_rdy got drop want steady 1"); else passed++;
        checks++; if (early_vld) $display("FAIL stream_early_vld got 1 want 0 before word end"); else passed++;
        checks++; if (odata_vld !== 1'b1) $display("FAIL stream_vld got %b want 1", odata_vld); else passed++;
        checks++; if (odata !== 32'h44332211) $display("FAIL stream_data got %h want 44332211", odata); else passed++;
        checks++; if (odata_keep !== 4'b1111) $display("FAIL stream_keep got %b want 1111", odata_keep); else passed++;
        checks++; if (odata_last !== 1'b0) $display("FAIL stream_last got %b want 0", odata_last); else passed++;
        idle_cycle();
        checks++; if (odata_vld !== 1'b0) $display("FAIL stream_vld_one_cycle got %b want 0", odata_vld); else passed++;
    endtask

    task automatic test_early_last();
        odata_rdy = 1'b1;
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b1);
        checks++; if (odata_vld !== 1'b1) $display("FAIL early_vld got %b want 1", odata_vld); else passed++;
        checks++; if (odata !== 32'h0000B2A1) $display("FAIL early_data got %h want 0000b2a1", odata); else passed++;
        checks++; if (odata_keep !== 4'b0011) $display("FAIL early_keep got %b want 0011", odata_keep); else passed++;
        checks++; if (odata_last !== 1'b1) $display("FAIL early_last got %b want 1", odata_last); else passed++;
        send(8'hC3, 1'b1);
        checks++; if (odata !== 32'h000000C3) $display("FAIL early_next_lane0 got %h want 000000c3", odata); else passed++;
        checks++; if (odata_keep !== 4'b0001) $display("FAIL early_next_keep got %b want 0001", odata_keep); else passed++;
        idle_cycle();
    endtask

    task automatic test_backpressure();
        logic stall_rdy_ok;
        logic stable_ok;
        stall_rdy_ok = 1'b1; stable_ok = 1'b1;
        odata_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        checks++; if (odata !== 32'h04030201) $display("FAIL bp_first_data got %h want 04030201", odata); else passed++;
        idata = 8'h05; idata_vld = 1'b1; idata_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (idata_rdy !== 1'b0) stall_rdy_ok = 1'b0;
            if (odata !== 32'h04030201 || odata_keep !== 4'b1111 || odata_vld !== 1'b1) stable_ok = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (!stall_rdy_ok) $display("FAIL bp_stall_rdy got 1 want 0 during stall"); else passed++;
        checks++; if (!stable_ok) $display("FAIL bp_hold_stable got change want 04030201 held"); else passed++;
        odata_rdy = 1'b1;
        #1;
        checks++; if (idata_rdy !== 1'b1) $display("FAIL bp_release_rdy got %b want 1", idata_rdy); else passed++;
        @(posedge clk); #1;
        checks++; if (odata !== 32'h00000005 || odata_keep !== 4'b0001) $display("FAIL bp_beat5_kept got %h/%b want 00000005/0001", odata, odata_keep); else passed++;
        for (int i = 6; i <= 8; i++) send(8'(i), 1'b0);
        checks++; if (odata !== 32'h08070605 || odata_vld !== 1'b1) $display("FAIL bp_second_word got %h vld %b want 08070605 vld 1", odata, odata_vld); else passed++;
        idle_cycle();
    endtask

    task automatic test_simultaneous();
        odata_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b0);
        checks++; if (odata !== 32'h13121110) $display("FAIL sim_held got %h want 13121110", odata); else passed++;
        idata = 8'h55; idata_vld = 1'b1; idata_last = 1'b0; odata_rdy = 1'b1;
        #1;
        checks++; if (idata_rdy !== 1'b1) $display("FAIL sim_rdy got %b want 1", idata_rdy); else passed++;
        @(posedge clk); #1;
        checks++; if (odata_vld !== 1'b0 || odata_keep !== 4'b0001 || odata !== 32'h00000055) $display("FAIL sim_lane0 got %h/%b vld %b want 00000055/0001 vld 0", odata, odata_keep, odata_vld); else passed++;
        send(8'h56, 1'b0);
        send(8'h57, 1'b0);
        send(8'h58, 1'b0);
        checks++; if (odata !== 32'h58575655) $display("FAIL sim_word got %h want 58575655", odata); else passed++;
        send(8'h99, 1'b1);
        checks++; if (odata_vld !== 1'b1 || odata !== 32'h00000099 || odata_keep !== 4'b0001 || odata_last !== 1'b1) $display("FAIL sim_hold_to_hold got %h/%b last %b want 00000099/0001 last 1", odata, odata_keep, odata_last); else passed++;
        idle_cycle();
        checks++; if (odata_vld !== 1'b0) $display("FAIL sim_drain got %b want 0", odata_vld); else passed++;
    endtask

    task automatic test_single_beat();
        logic [7:0] beats [3];
        beats = '{8'h7E, 8'h7F, 8'h80};
        odata_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(beats[i], 1'b1);
            checks++;
            if (odata_vld !== 1'b1 || odata !== {24'h0, beats[i]} || odata_keep !== 4'b0001 || odata_last !== 1'b1)
                $display("FAIL single_%0d got %h/%b last %b vld %b want %h/0001 last 1 vld 1",
                         i, odata, odata_keep, odata_last, odata_vld, {24'h0, beats[i]});
            else passed++;
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_word();
        odata_rdy = 1'b1;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        idata_vld = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++; if (odata_keep !== 4'b0000 || odata !== 32'h0) $display("FAIL rst_mid_clear got %h/%b want 00000000/0000", odata, odata_keep); else passed++;
        checks++; if (odata_vld !== 1'b0 || idata_rdy !== 1'b0) $display("FAIL rst_mid_vld_rdy got vld %b rdy %b want 0 0", odata_vld, idata_rdy); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        checks++; if (odata !== 32'h04030201 || odata_keep !== 4'b1111 || odata_vld !== 1'b1) $display("FAIL rst_mid_after got %h/%b want 04030201/1111", odata, odata_keep); else passed++;
        idle_cycle();
        odata_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'h20 + 8'(i), 1'b0);
        idata_vld = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++; if (odata_vld !== 1'b0) $display("FAIL rst_hold_vld got %b want 0", odata_vld); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        odata_rdy = 1'b1;
        @(posedge clk); #1;
        checks++; if (odata_vld !== 1'b0) $display("FAIL rst_hold_no_emit got %b want 0", odata_vld); else passed++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_early_last();
        test_backpressure();
        test_simultaneous();
        test_single_beat();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
